// File: rtl/versat_agu_pkg.sv
// versat_agu_pkg: shared state encoding and default widths for the Versat memory AGU
package versat_agu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int ADDR_W_DEF  = 6;
    localparam int CNT_W_DEF   = 10;
    localparam int DELAY_W_DEF = 8;

endpackage

// File: rtl/versat_agu_loop.sv
// versat_agu_loop: wrap counter 0..max-1 that latches its limit on load
module versat_agu_loop #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] nxt_o,
    output logic         last_o,
    output logic         zero_o
);

    logic [W-1:0] max_q, max_d, cnt_q, cnt_d;

    assign last_o = cnt_q == max_q - 1'b1;
    assign zero_o = max_q == '0;
    assign nxt_o  = cnt_d;

    // load clears the count and captures the limit; enable steps and wraps on last
    always_comb begin
        max_d = load_i ? max_i : max_q;
        cnt_d = load_i ? '0 : en_i ? (last_o ? '0 : cnt_q + 1'b1) : cnt_q;
    end

    // state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            max_q <= '0;
            cnt_q <= '0;
        end else begin
            max_q <= max_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/versat_mem_agu.sv
// versat_mem_agu: 2-level loop address generator driving one Versat memory port
module versat_mem_agu
    import versat_agu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DELAY_W = DELAY_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               run_i,
    input  logic [ADDR_W-1:0]  start_addr_i,
    input  logic [ADDR_W-1:0]  incr_i,
    input  logic [ADDR_W-1:0]  shift_i,
    input  logic [CNT_W-1:0]   per_i,
    input  logic [CNT_W-1:0]   duty_i,
    input  logic [CNT_W-1:0]   iter_i,
    input  logic [DELAY_W-1:0] delay_i,
    input  logic               write_i,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               en_o,
    output logic               we_o,
    output logic               rvalid_o,
    output logic               done_o
);

    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, start_q, start_d, incr_q, incr_d, shift_q, shift_d;
    logic [CNT_W-1:0] duty_q, duty_d, pc_nxt, ic_nxt_unused;
    logic [DELAY_W-1:0] delay_q, delay_d, dly_q, dly_d;
    logic en_q, en_d, we_q, we_d, rv_q, rv_d, done_q, done_d, write_q, write_d;
    logic load, pc_en, ic_en, go_run, pc_last, ic_last, per_zero, iter_zero;

    assign addr_o   = addr_q;
    assign en_o     = en_q;
    assign we_o     = we_q;
    assign rvalid_o = rv_q;
    assign done_o   = done_q;

    versat_agu_loop #(.W(CNT_W)) u_pc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load),
        .en_i   (pc_en),
        .max_i  (per_i),
        .nxt_o  (pc_nxt),
        .last_o (pc_last),
        .zero_o (per_zero)
    );

    versat_agu_loop #(.W(CNT_W)) u_ic (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load),
        .en_i   (ic_en),
        .max_i  (iter_i),
        .nxt_o  (ic_nxt_unused),
        .last_o (ic_last),
        .zero_o (iter_zero)
    );

    // next-state, shadow config and registered port values for the coming cycle
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        en_d    = 1'b0;
        done_d  = 1'b0;
        dly_d   = dly_q;
        start_d = start_q;
        incr_d  = incr_q;
        shift_d = shift_q;
        duty_d  = duty_q;
        delay_d = delay_q;
        write_d = write_q;
        load    = 1'b0;
        pc_en   = 1'b0;
        ic_en   = 1'b0;
        go_run  = 1'b0;
        case (state_q)
            IDLE: begin
                done_d = 1'b1;
                if (run_i) begin
                    load    = 1'b1;
                    start_d = start_addr_i;
                    incr_d  = incr_i;
                    shift_d = shift_i;
                    duty_d  = duty_i;
                    delay_d = delay_i;
                    write_d = write_i;
                    dly_d   = '0;
                    done_d  = 1'b0;
                    if (delay_i != '0) begin
                        state_d = DELAY;
                    end else if (per_i != '0 && iter_i != '0) begin
                        state_d = RUN;
                        go_run  = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (dly_q == delay_q - 1'b1) begin
                    state_d = (per_zero || iter_zero) ? IDLE : RUN;
                    done_d  = per_zero || iter_zero;
                    go_run  = !(per_zero || iter_zero);
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            RUN: begin
                pc_en  = 1'b1;
                ic_en  = pc_last;
                addr_d = addr_q + (pc_last ? shift_q : incr_q);
                en_d   = pc_nxt < duty_q;
                if (pc_last && ic_last) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // first RUN cycle: pc is 0, so the port is enabled iff duty is nonzero
        if (go_run) begin
            addr_d = start_d;
            en_d   = duty_d != '0;
        end
        we_d = en_d & write_d;
        rv_d = en_q & ~we_q;
    end

    // state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            rv_q    <= 1'b0;
            done_q  <= 1'b1;
            dly_q   <= '0;
            start_q <= '0;
            incr_q  <= '0;
            shift_q <= '0;
            duty_q  <= '0;
            delay_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            we_q    <= we_d;
            rv_q    <= rv_d;
            done_q  <= done_d;
            dly_q   <= dly_d;
            start_q <= start_d;
            incr_q  <= incr_d;
            shift_q <= shift_d;
            duty_q  <= duty_d;
            delay_q <= delay_d;
            write_q <= write_d;
        end
    end

endmodule

// File: tb/tb_versat_mem_agu.sv
// tb_versat_mem_agu: directed and random sequences checked against a closed-form trace model
module tb_versat_mem_agu;

    logic clk = 1'b0;
    logic rst, run, write, en, we, rvalid, done;
    logic [5:0] start_addr, incr, shift, addr;
    logic [9:0] per, duty, iter;
    logic [7:0] delay;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    versat_mem_agu dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .run_i        (run),
        .start_addr_i (start_addr),
        .incr_i       (incr),
        .shift_i      (shift),
        .per_i        (per),
        .duty_i       (duty),
        .iter_i       (iter),
        .delay_i      (delay),
        .write_i      (write),
        .addr_o       (addr),
        .en_o         (en),
        .we_o         (we),
        .rvalid_o     (rvalid),
        .done_o       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic scramble;
        start_addr = 6'($urandom);
        incr       = 6'($urandom);
        shift      = 6'($urandom);
        per        = 10'($urandom_range(0, 7));
        duty       = 10'($urandom_range(0, 7));
        iter       = 10'($urandom_range(0, 3));
        delay      = 8'($urandom_range(0, 3));
        write      = 1'($urandom);
    endtask

    // Expected trace from cycle k+1: delay idle cycles, then iter*per RUN cycles whose
    // address is start + i*((per-1)*incr + shift) + j*incr, then two idle cycles.
    task automatic run_seq(input string name, input logic [5:0] st, input logic [5:0] inc,
                           input logic [5:0] sh, input logic [9:0] p, input logic [9:0] du,
                           input logic [9:0] it, input logic [7:0] dl, input logic wr,
                           input int poke);
        bit ee[$];
        bit ed[$];
        bit er[$];
        logic [5:0] ea[$];
        bit rv;
        rv = 1'b0;
        for (int c = 0; c < int'(dl); c++) begin
            ee.push_back(1'b0); ed.push_back(1'b0); er.push_back(1'b0); ea.push_back(6'd0);
        end
        if (p != 0 && it != 0) begin
            for (int i = 0; i < int'(it); i++)
                for (int j = 0; j < int'(p); j++) begin
                    ea.push_back(6'(int'(st) + i * (int'(inc) * (int'(p) - 1) + int'(sh)) + j * int'(inc)));
                    ee.push_back(j < int'(du));
                    ed.push_back(1'b0);
                    er.push_back(1'b1);
                end
        end else if (dl == 0) begin
            ee.push_back(1'b0); ed.push_back(1'b0); er.push_back(1'b0); ea.push_back(6'd0);
        end
        for (int c = 0; c < 2; c++) begin
            ee.push_back(1'b0); ed.push_back(1'b1); er.push_back(1'b0); ea.push_back(6'd0);
        end
        @(negedge clk);
        start_addr = st; incr = inc; shift = sh; per = p; duty = du; iter = it;
        delay = dl; write = wr; run = 1'b1;
        step();
        run = 1'b0;
        scramble();
        for (int c = 0; c < ee.size(); c++) begin
            chk($sformatf("%s en c%0d", name, c), en, ee[c]);
            chk($sformatf("%s we c%0d", name, c), we, ee[c] & wr);
            chk($sformatf("%s done c%0d", name, c), done, ed[c]);
            chk($sformatf("%s rvalid c%0d", name, c), rvalid, rv);
            if (er[c]) chk($sformatf("%s addr c%0d", name, c), addr, ea[c]);
            rv = ee[c] & ~wr;
            run = (c == poke);
            step();
        end
        run = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        scramble();
        step();
        step();
        chk("reset addr", addr, 6'd0);
        chk("reset en", en, 1'b0);
        chk("reset we", we, 1'b0);
        chk("reset rvalid", rvalid, 1'b0);
        chk("reset done", done, 1'b1);
        rst = 1'b0;
        step();

        run_seq("linear", 6'd4, 6'd1, 6'd1, 10'd4, 10'd4, 10'd1, 8'd0, 1'b0, -1);
        run_seq("2d_delay", 6'd0, 6'd1, 6'd5, 10'd3, 10'd3, 10'd2, 8'd2, 1'b1, -1);
        run_seq("duty_wrap", 6'd62, 6'd1, 6'd1, 10'd4, 10'd2, 10'd2, 8'd0, 1'b0, -1);
        run_seq("iter0", 6'd9, 6'd1, 6'd1, 10'd4, 10'd4, 10'd0, 8'd0, 1'b0, -1);
        run_seq("per0_delay", 6'd9, 6'd1, 6'd1, 10'd0, 10'd4, 10'd3, 8'd3, 1'b1, -1);
        run_seq("duty0", 6'd1, 6'd2, 6'd3, 10'd3, 10'd0, 10'd2, 8'd0, 1'b1, -1);
        run_seq("neg_step", 6'd5, 6'd63, 6'd60, 10'd3, 10'd9, 10'd2, 8'd1, 1'b0, -1);
        run_seq("poke", 6'd20, 6'd1, 6'd8, 10'd3, 10'd2, 10'd2, 8'd0, 1'b1, 2);

        @(negedge clk);
        start_addr = 6'd10; incr = 6'd2; shift = 6'd2; per = 10'd5; duty = 10'd5;
        iter = 10'd2; delay = 8'd0; write = 1'b1; run = 1'b1;
        step();
        run = 1'b0;
        chk("mid en c0", en, 1'b1);
        chk("mid addr c0", addr, 6'd10);
        step();
        step();
        chk("mid addr c2", addr, 6'd14);
        chk("mid we c2", we, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid rst en", en, 1'b0);
        chk("mid rst we", we, 1'b0);
        chk("mid rst done", done, 1'b1);
        chk("mid rst addr", addr, 6'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("mid quiet en c%0d", c), en, 1'b0);
            chk($sformatf("mid quiet done c%0d", c), done, 1'b1);
        end
        run_seq("after_rst", 6'd33, 6'd3, 6'd7, 10'd2, 10'd1, 10'd3, 8'd1, 1'b1, -1);

        for (int r = 0; r < 20; r++)
            run_seq($sformatf("rnd%0d", r), 6'($urandom), 6'($urandom), 6'($urandom),
                    10'($urandom_range(0, 5)), 10'($urandom_range(0, 6)),
                    10'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 1'($urandom), -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/versat_mem_agu.md
Name: versat_mem_agu

Overview:
- Address-generation controller that sequences one port of the dual-port Versat memory.
- A `run_i` pulse latches a 2-level loop configuration. The block then drives the port's address, enable and write-enable for `iter × per` cycles.
- Optional start delay and duty cycle are supported.
- Two instances sit beside each Versat memory unit, one per port. Their `addr_o`, `en_o` and `we_o` connect directly to the memory's per-port address/enable/write-enable inputs.

Parameters:
ADDR_W, 6, memory address width (must match the memory's ADDR_W)
CNT_W, 10, width of the period, duty and iteration counters
DELAY_W, 8, width of the start-delay counter

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
run_i  in  1  start pulse; sampled only in IDLE
start_addr_i  in  ADDR_W  first address
incr_i  in  ADDR_W  two's-complement step inside a period
shift_i  in  ADDR_W  two's-complement step applied at each period boundary (replaces incr_i on that cycle)
per_i  in  CNT_W  cycles per period
duty_i  in  CNT_W  enabled cycles at the start of each period
iter_i  in  CNT_W  number of periods
delay_i  in  DELAY_W  idle cycles between run_i and the first RUN cycle
write_i  in  1  1 = write sequence, 0 = read sequence
addr_o  out  ADDR_W  memory address (registered)
en_o  out  1  memory port enable (registered)
we_o  out  1  memory port write enable (registered)
rvalid_o  out  1  read data valid on the memory data-out port (registered)
done_o  out  1  high while idle

Behaviour:
- Reset (synchronous, rst_i high at an edge):
  - state := IDLE; addr_o, en_o, we_o, rvalid_o := 0; done_o := 1; all counters := 0.
  - Reset mid-sequence aborts immediately; no further accesses occur.
- FSM states: IDLE, DELAY, RUN.
- IDLE:
  - done_o = 1, en_o = 0.
  - run_i high at edge k latches all configuration inputs into shadow registers; done_o = 0 from cycle k+1.
  - Next state: DELAY if delay_i ≠ 0; RUN if delay_i = 0 and per_i ≠ 0 and iter_i ≠ 0; otherwise IDLE.
  - If the next state is IDLE (empty sequence), done_o drops for exactly one cycle and no access is issued.
- DELAY:
  - Counts latched delay cycles; en_o = 0.
  - After exactly `delay` cycles, moves to RUN, or to IDLE if per or iter is 0.
- RUN:
  - Per-cycle counters: pc (0..per-1) and ic (0..iter-1).
  - In each RUN cycle: en_o = (pc < min(duty, per)); we_o = en_o & write; addr_o = current address.
  - First RUN cycle: addr_o = start_addr.
  - Address update:
    - pc < per-1: next addr = addr + incr.
    - pc = per-1: next addr = addr + shift.
    - All arithmetic is modulo 2^ADDR_W (wrap-around, no saturation).
  - The address advances every RUN cycle, including cycles where en_o is low (duty gating does not freeze the address).
  - On pc = per-1: pc := 0 and ic := ic+1. If ic = iter-1, go to IDLE.
- Latency with delay = 0:
  - run_i sampled at edge k → first en_o at cycle k+1.
  - Last en_o opportunity at cycle k+iter·per.
  - done_o = 1 from cycle k+iter·per+1.
- Latency with delay = d: every RUN cycle shifts later by d.
- Duty:
  - duty = 0: no enables, but RUN still lasts iter·per cycles.
  - duty ≥ per: en_o high for the whole period.
- rvalid_o: one-cycle-delayed copy of (en_o & ~we_o), aligned with the memory's registered read data.
- run_i outside IDLE is ignored; the shadow configuration is unaffected.
- Configuration inputs may change freely after the run_i cycle.

Decomposition:
- Package versat_agu_pkg holds:
  - FSM state encoding localparams: IDLE = 2'd0, DELAY = 2'd1, RUN = 2'd2.
  - Defaults: ADDR_W = 6, CNT_W = 10, DELAY_W = 8.
- One natural sub-module, versat_agu_loop:
  - Parameterised wrap counter with load, enable and last-flag outputs.
  - Instantiated twice: period counter and iteration counter.
- Address adder and FSM stay in the top module.

Test Plan:
- Reset: hold rst_i 2 cycles → addr_o = 0, en_o = 0, we_o = 0, rvalid_o = 0, done_o = 1.
- Linear read: start=4, incr=1, shift=1, per=4, duty=4, iter=1, delay=0, write=0, run at k → addr_o 4,5,6,7 with en_o = 1 at k+1..k+4; rvalid_o at k+2..k+5; done_o = 1 at k+5.
- 2D write with delay: start=0, incr=1, shift=5, per=3, duty=3, iter=2, delay=2 → en_o = we_o = 1 at k+3..k+8, addresses 0,1,2,7,8,9.
- Duty and wrap: start=62, incr=1, shift=1, per=4, duty=2, iter=2 → addresses 62,63,0,1,2,3,4,5; en_o = 1,1,0,0,1,1,0,0.
- Edge cases:
  - iter=0 → no en_o; done_o low for exactly 1 cycle.
  - run_i asserted during RUN → ignored, sequence unchanged.
- Reset mid-RUN: assert rst_i on the 3rd RUN cycle → en_o = 0 next cycle, done_o = 1, no further accesses; a subsequent run_i starts cleanly.
